// File: rtl/disp_msg_sched.sv
// disp_msg_sched: prioritised message scheduler that alternates timed text messages with the BCD score display.
module disp_msg_sched #(
  parameter int TICK_DIV    = 100000,
  parameter int HOLD_TICKS  = 2000,
  parameter int SCORE_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] score_l,
  input  logic [6:0] score_r,
  input  logic       req_slow,
  input  logic       req_med,
  input  logic       req_fast,
  input  logic       req_error,
  input  logic       req_wrong,
  input  logic       clr,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic       text_mode,
  output logic       slow,
  output logic       med,
  output logic       fast,
  output logic       error,
  output logic       wrong,
  output logic       busy
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int MT = HOLD_TICKS > SCORE_TICKS ? HOLD_TICKS : SCORE_TICKS;
  localparam int KW = $clog2(MT + 1);
  typedef enum logic [1:0] {SCORE, SHOW, GAP} state_t;
  state_t          state_q, state_d;
  logic [4:0]      sel_q, sel_d, pend_q, pend_d, req, hi;
  logic [TW-1:0]   presc_q, presc_d;
  logic [KW-1:0]   tick_q, tick_d;
  logic            restart, expire, wrap, zero;
  function automatic logic [4:0] top(input logic [4:0] m);
    return m[4] ? 5'b10000 : m[3] ? 5'b01000 : m[2] ? 5'b00100 : m[1] ? 5'b00010 : m[0] ? 5'b00001 : 5'b00000;
  endfunction
  function automatic logic [7:0] bcd(input logic [6:0] s);
    logic [6:0] v;
    v = s > 7'd99 ? 7'd99 : s;
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction
  // bits ordered by priority: slow lowest, wrong highest
  assign req  = {req_wrong, req_error, req_fast, req_med, req_slow};
  assign hi   = req & ~(sel_q | (sel_q - 5'd1));
  assign wrap = presc_q == TW'(TICK_DIV - 1);
  assign expire = wrap && tick_q == (state_q == SHOW ? KW'(HOLD_TICKS - 1) : KW'(SCORE_TICKS - 1));
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q | req;
    restart = 1'b0;
    case (state_q)
      SCORE: if (|pend_d) begin
        state_d = SHOW;
        sel_d   = top(pend_d);
        restart = 1'b1;
      end
      SHOW: if (|hi) begin
        sel_d   = top(hi);
        restart = 1'b1;
      end else if (|(req & sel_q)) begin
        restart = 1'b1;
      end else if (expire) begin
        state_d = |pend_d ? GAP : SCORE;
        sel_d   = '0;
        restart = 1'b1;
      end
      GAP: if (expire) begin
        state_d = SHOW;
        sel_d   = top(pend_d);
        restart = 1'b1;
      end
      default: state_d = SCORE;
    endcase
    // the shown message and any preempted one never linger in pending
    pend_d = pend_d & ~sel_d & ~sel_q;
    if (clr) begin
      state_d = SCORE;
      sel_d   = '0;
      pend_d  = '0;
      restart = 1'b1;
    end
    zero    = restart || state_d == SCORE;
    presc_d = zero || wrap ? '0 : presc_q + 1'b1;
    tick_d  = zero ? '0 : wrap ? tick_q + 1'b1 : tick_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCORE;
      sel_q   <= '0;
      pend_q  <= '0;
      presc_q <= '0;
      tick_q  <= '0;
      {D3, D2, D1, D0} <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      {D3, D2} <= bcd(score_l);
      {D1, D0} <= bcd(score_r);
    end
  end
  assign text_mode = state_q == SHOW;
  assign {wrong, error, fast, med, slow} = sel_q;
  assign busy = state_q != SCORE || |pend_q;
endmodule
